// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operand latch, one prep cycle,
// 32 shift-add / restoring-divide iterations, one result cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_e;

    state_e      state_q;
    logic [2:0]  f3_q;
    logic [31:0] a_q, b_q, m_q, result_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic        negq_q, negr_q, bz_q, done_q;

    logic        is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] acc_d, prod_fix;
    logic [31:0] quo_fix, rem_fix, res_d;

    always_comb begin
        is_div = f3_q[2];
        a_sgn  = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
        b_sgn  = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
        a_neg  = a_sgn & a_q[31];
        b_neg  = b_sgn & b_q[31];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
    end

    // acc_q holds {high product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        div_sh   = {acc_q[63:32], acc_q[31]};
        div_diff = div_sh - {1'b0, m_q};
        if (is_div) begin
            if (div_diff[32])
                acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
            else
                acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end
    end

    always_comb begin
        prod_fix = negq_q ? -acc_q : acc_q;
        quo_fix  = negq_q ? -acc_q[31:0] : acc_q[31:0];
        rem_fix  = negr_q ? -acc_q[63:32] : acc_q[63:32];
        res_d    = prod_fix[63:32];
        case (f3_q)
            3'b000:         res_d = prod_fix[31:0];
            3'b100, 3'b101: res_d = bz_q ? 32'hFFFF_FFFF : quo_fix;
            3'b110, 3'b111: res_d = bz_q ? a_q : rem_fix;
            default:        res_d = prod_fix[63:32];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            f3_q     <= 3'b000;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            m_q      <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            bz_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f3_q    <= funct3;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    m_q     <= is_div ? b_mag : a_mag;
                    acc_q   <= {32'd0, is_div ? a_mag : b_mag};
                    negq_q  <= a_neg ^ b_neg;
                    negr_q  <= a_neg;
                    bz_q    <= (b_q == 32'd0);
                    cnt_q   <= 5'd0;
                    state_q <= CALC;
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_q <= DONE;
                end
                DONE: begin
                    result_q <= res_d;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vectors, busy/DONE/reset sequences and a
// random back-to-back regression against a 64-bit arithmetic model.
module tb_muldiv_unit;

    logic        clk, reset, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        ready, busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy),
        .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op on the first ready cycle; returns result and edges to done.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait: ready still low after %0d cycles", guard);
        end
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        lat    = 0;
        res    = 32'hxxxx_xxxx;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    vec_t tbl[16];

    initial begin
        logic [31:0] res, first_res;
        int lat, ndone, first_k;

        tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[2]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[5]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        tbl[6]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        tbl[7]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC};
        tbl[8]  = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001};
        tbl[9]  = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[10] = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[11] = '{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        tbl[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[14] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[15] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};

        // Reset asserted together with start must win.
        reset = 1'b1;
        start = 1'b1;
        funct3 = 3'd0;
        op_a = 32'd5;
        op_b = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i].f3, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
        end

        // Starts at cycles 5 and 20 of a running op are dropped.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'h0000_0007; op_b = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd3;
        ndone = 0; first_k = 0; first_res = 32'd0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 20);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin first_k = k; first_res = result; end
            end
        end
        start = 1'b0;
        check("busy_start_done_count", 32'(ndone), 32'd1);
        check("busy_start_latency", 32'(first_k), 32'd34);
        check("busy_start_result", first_res, 32'hFFFF_FFEB);
        check("result_held", result, 32'hFFFF_FFEB);

        // Start in the DONE state is ignored; start in the next IDLE cycle is taken.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; first_k = 0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (k == 34 || k == 35) begin
                start = 1'b1; funct3 = 3'd7; op_a = 32'd100; op_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k == 34) begin
                check("done_cycle_done", {31'd0, done}, 32'd1);
                check("done_cycle_ready", {31'd0, ready}, 32'd1);
                check("done_cycle_result", result, 32'hFFFF_FFFD);
            end
            if (k == 35) check("b2b_accept_ready", {31'd0, ready}, 32'd0);
            if (k == 50) check("result_held_busy", result, 32'hFFFF_FFFD);
            if (done && k > 34 && first_k == 0) begin
                first_k = k;
                check("b2b_result", result, 32'd2);
            end
        end
        start = 1'b0;
        check("b2b_latency", 32'(first_k), 32'd69);

        // Reset in cycle 15 of an op aborts it.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat);
        check("after_abort_result", res, 32'hFFFF_FFFF);
        check("after_abort_latency", 32'(lat), 32'd34);

        // Random back-to-back regression.
        for (int i = 0; i < 2000; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            do_op(f, a, b, res, lat);
            check($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), res, ref_model(f, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd34);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
